// File: rtl/mxalu_arb.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// SETTLE-cycle operand hold with chip select, then a held response until accepted.
module mxalu_arb #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_opcode,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_opcode,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_f,
    output logic       rsp_carry,
    output logic       rsp_eq,
    output logic       rsp_zero,
    output logic       rsp_id,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cs_n,
    input  logic [7:0] alu_f,
    input  logic       alu_cn8_n,
    input  logic       alu_a_b,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_id_q, last_id_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       id_q, id_d;
    logic [7:0] rsp_f_q, rsp_f_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_eq_q, rsp_eq_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_id_q, rsp_id_d;
    logic       grant0, grant1;

    // On a tie the requester that did not own the last response wins.
    assign grant0 = (state_q == IDLE) & rst_n & req0_valid & (~req1_valid | last_id_q);
    assign grant1 = (state_q == IDLE) & rst_n & req1_valid & (~req0_valid | ~last_id_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_f_d     = rsp_f_q;
        rsp_carry_d = rsp_carry_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    op_d    = grant1 ? req1_opcode : req0_opcode;
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    id_d    = grant1;
                    cnt_d   = SETTLE_M1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_f_d     = alu_f;
                    rsp_carry_d = ~alu_cn8_n;
                    rsp_eq_d    = alu_a_b;
                    rsp_zero_d  = (alu_f == 8'h00);
                    rsp_id_d    = id_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_id_d = rsp_id_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_id_q   <= 1'b1;
            op_q        <= 4'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            id_q        <= 1'b0;
            rsp_f_q     <= 8'd0;
            rsp_carry_q <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_f_q     <= rsp_f_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Operand registers feed the ALU directly, so they hold outside EXEC.
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cs_n   = (state_q != EXEC);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_f      = rsp_f_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_eq     = rsp_eq_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mxalu_arb.sv
// Bench for mxalu_arb: directed scenarios on SETTLE=1 and SETTLE=3 instances plus
// a randomized run against a transaction-age reference model.
module tb_mxalu_arb;

    logic       clk = 1'b0;
    logic       rst1_n, rst3_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_opcode, req1_opcode;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;

    logic       r0rdy_1, r1rdy_1, rv_1, c_1, e_1, z_1, id_1, cs_1, busy_1, cn8_1, ab_1;
    logic [7:0] f_1, aa_1, ab8_1, af_1;
    logic [3:0] op_1;
    logic       r0rdy_3, r1rdy_3, rv_3, c_3, e_3, z_3, id_3, cs_3, busy_3, cn8_3, ab_3;
    logic [7:0] f_3, aa_3, ab8_3, af_3;
    logic [3:0] op_3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // ALU stand-in: add with an opcode-dependent twist; garbage while deselected.
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {a == b, ~s[8], s[7:0] ^ {4'h0, op ^ 4'h9}};
    endfunction

    assign {ab_1, cn8_1, af_1} = cs_1 ? 10'h0EE : alu_fn(op_1, aa_1, ab8_1);
    assign {ab_3, cn8_3, af_3} = cs_3 ? 10'h0EE : alu_fn(op_3, aa_3, ab8_3);

    mxalu_arb #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .req0_valid(req0_valid), .req0_ready(r0rdy_1), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1rdy_1), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rv_1), .rsp_ready(rsp_ready), .rsp_f(f_1), .rsp_carry(c_1), .rsp_eq(e_1),
        .rsp_zero(z_1), .rsp_id(id_1), .alu_opcode(op_1), .alu_a(aa_1), .alu_b(ab8_1),
        .alu_cs_n(cs_1), .alu_f(af_1), .alu_cn8_n(cn8_1), .alu_a_b(ab_1), .busy(busy_1)
    );

    mxalu_arb #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req0_valid(req0_valid), .req0_ready(r0rdy_3), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1rdy_3), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rv_3), .rsp_ready(rsp_ready), .rsp_f(f_3), .rsp_carry(c_3), .rsp_eq(e_3),
        .rsp_zero(z_3), .rsp_id(id_3), .alu_opcode(op_3), .alu_a(aa_3), .alu_b(ab8_3),
        .alu_cs_n(cs_3), .alu_f(af_3), .alu_cn8_n(cn8_3), .alu_a_b(ab_3), .busy(busy_3)
    );

    task automatic rst1();
        @(negedge clk); rst1_n = 1'b0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst1_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        n_tests++; if ({r0rdy_1, r1rdy_1} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {r0rdy_1, r1rdy_1}); end
        n_tests++; if ({rv_1, f_1, c_1, e_1, z_1, id_1} !== 13'd0) begin n_fail++; $display("FAIL reset_rsp got %h want 0", {rv_1, f_1, c_1, e_1, z_1, id_1}); end
        n_tests++; if ({op_1, aa_1, ab8_1} !== 20'd0) begin n_fail++; $display("FAIL reset_alu got %h want 0", {op_1, aa_1, ab8_1}); end
        n_tests++; if (cs_1 !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", cs_1); end
        n_tests++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_1); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); rst1_n = 1'b1;
    endtask

    task automatic test_basic();
        rst1();
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 4'h9; req0_a = 8'h3C; req0_b = 8'h0F; req1_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        n_tests++; if ({r0rdy_1, r1rdy_1} !== 2'b10) begin n_fail++; $display("FAIL basic_grant got %b want 10", {r0rdy_1, r1rdy_1}); end
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 8'hFF; req0_opcode = 4'h0;
        #1;
        n_tests++; if ({cs_1, rv_1} !== 2'b00) begin n_fail++; $display("FAIL basic_exec got cs_n,valid=%b want 00", {cs_1, rv_1}); end
        n_tests++; if ({op_1, aa_1, ab8_1} !== 20'h93C0F) begin n_fail++; $display("FAIL basic_alu_in got %h want 93c0f", {op_1, aa_1, ab8_1}); end
        @(negedge clk); #1;
        n_tests++; if ({cs_1, rv_1} !== 2'b11) begin n_fail++; $display("FAIL basic_resp got cs_n,valid=%b want 11", {cs_1, rv_1}); end
        n_tests++; if ({f_1, c_1, e_1, z_1, id_1} !== {8'h4B, 4'b0000}) begin n_fail++; $display("FAIL basic_rsp got %h want %h", {f_1, c_1, e_1, z_1, id_1}, {8'h4B, 4'b0000}); end
        @(negedge clk); #1;
        n_tests++; if ({busy_1, rv_1} !== 2'b00) begin n_fail++; $display("FAIL basic_idle got busy,valid=%b want 00", {busy_1, rv_1}); end
    endtask

    task automatic test_round_robin();
        logic er0, er1, erv;
        rst1();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_opcode = 4'h9; req0_a = 8'h01; req0_b = 8'h02; req1_opcode = 4'h9; req1_a = 8'h11; req1_b = 8'h22;
        for (int k = 0; k < 12; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            er0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
            er1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
            erv = (k % 3 == 2);
            n_tests++; if ({r0rdy_1, r1rdy_1, rv_1} !== {er0, er1, erv}) begin n_fail++; $display("FAIL rr_cycle%0d got rdy0,rdy1,valid=%b want %b", k, {r0rdy_1, r1rdy_1, rv_1}, {er0, er1, erv}); end
            if (erv) begin
                n_tests++; if (id_1 !== 1'((k / 3) % 2)) begin n_fail++; $display("FAIL rr_id%0d got %b want %0d", k, id_1, (k / 3) % 2); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_zero();
        rst1();
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 4'h9; req0_a = 8'h80; req0_b = 8'h80; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++; if ({rv_1, f_1, c_1, e_1, z_1} !== {1'b1, 8'h00, 3'b111}) begin n_fail++; $display("FAIL zero_rsp got %h want %h", {rv_1, f_1, c_1, e_1, z_1}, {1'b1, 8'h00, 3'b111}); end
    endtask

    task automatic test_backpressure();
        rst1();
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 4'h3; req0_a = 8'h12; req0_b = 8'h34; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (rv_1 !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid got %b want 1", rv_1); end
        req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 8'h77; req1_a = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_tests++; if ({rv_1, f_1, c_1, e_1, z_1, id_1} !== {1'b1, 8'h4C, 4'b0000}) begin n_fail++; $display("FAIL bp_hold%0d got %h want %h", i, {rv_1, f_1, c_1, e_1, z_1, id_1}, {1'b1, 8'h4C, 4'b0000}); end
            n_tests++; if ({r0rdy_1, r1rdy_1, busy_1} !== 3'b001) begin n_fail++; $display("FAIL bp_ready%0d got rdy0,rdy1,busy=%b want 001", i, {r0rdy_1, r1rdy_1, busy_1}); end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        n_tests++; if (rv_1 !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid got %b want 1", rv_1); end
        @(negedge clk); #1;
        n_tests++; if ({busy_1, rv_1} !== 2'b00) begin n_fail++; $display("FAIL bp_idle got busy,valid=%b want 00", {busy_1, rv_1}); end
    endtask

    task automatic test_random();
        bit         m_busy, m_last, g0, g1, erv, ecs;
        int         m_age;
        logic [3:0] eop;
        logic [7:0] ea, eb, ef;
        logic [8:0] s;
        bit         ec, ee, ez, eid;
        rst3_n = 1'b0;
        rst1();
        m_busy = 0; m_last = 1; m_age = 0;
        eop = '0; ea = '0; eb = '0; ef = '0; ec = 0; ee = 0; ez = 0; eid = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_opcode = 4'($urandom); req1_opcode = 4'($urandom);
            req0_a = 8'($urandom); req0_b = ($urandom_range(0, 7) == 0) ? req0_a : 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g0 = !m_busy && req0_valid && (!req1_valid || m_last);
            g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            erv = m_busy && (m_age > 1);
            ecs = !(m_busy && (m_age <= 1));
            n_tests++; if ({r0rdy_1, r1rdy_1} !== {g0, g1}) begin n_fail++; $display("FAIL rand_grant cyc%0d got %b want %b", n, {r0rdy_1, r1rdy_1}, {g0, g1}); end
            n_tests++; if ({rv_1, cs_1, busy_1} !== {erv, ecs, m_busy}) begin n_fail++; $display("FAIL rand_ctrl cyc%0d got valid,cs_n,busy=%b want %b", n, {rv_1, cs_1, busy_1}, {erv, ecs, m_busy}); end
            if (erv) begin
                n_tests++; if ({f_1, c_1, e_1, z_1, id_1} !== {ef, ec, ee, ez, eid}) begin n_fail++; $display("FAIL rand_rsp cyc%0d got %h want %h", n, {f_1, c_1, e_1, z_1, id_1}, {ef, ec, ee, ez, eid}); end
            end
            if (!ecs) begin
                n_tests++; if ({op_1, aa_1, ab8_1} !== {eop, ea, eb}) begin n_fail++; $display("FAIL rand_alu_in cyc%0d got %h want %h", n, {op_1, aa_1, ab8_1}, {eop, ea, eb}); end
            end
            if (!m_busy) begin
                if (g0 || g1) begin
                    eop = g1 ? req1_opcode : req0_opcode;
                    ea = g1 ? req1_a : req0_a;
                    eb = g1 ? req1_b : req0_b;
                    s = {1'b0, ea} + {1'b0, eb};
                    ef = s[7:0] ^ {4'h0, eop ^ 4'h9};
                    ec = s[8]; ee = (ea == eb); ez = (ef == 8'h00); eid = g1;
                    m_busy = 1; m_age = 1;
                end
            end else if (m_age > 1 && rsp_ready) begin
                m_busy = 0; m_last = eid;
            end else begin
                m_age++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst1_n = 1'b0;
        @(negedge clk); rst3_n = 1'b0;
        repeat (2) @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_opcode = 4'h1; req0_a = 8'h05; req0_b = 8'h06; req1_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        n_tests++; if (r0rdy_3 !== 1'b1) begin n_fail++; $display("FAIL mid_grant got %b want 1", r0rdy_3); end
        @(negedge clk); req0_valid = 1'b0; #1;
        n_tests++; if (cs_3 !== 1'b0) begin n_fail++; $display("FAIL mid_exec1 cs_n got %b want 0", cs_3); end
        @(negedge clk);
        rst3_n = 1'b0; req0_valid = 1'b1;
        #1;
        n_tests++; if ({cs_3, busy_3, rv_3, r0rdy_3, r1rdy_3} !== 5'b10000) begin n_fail++; $display("FAIL mid_abort got cs_n,busy,valid,rdy0,rdy1=%b want 10000", {cs_3, busy_3, rv_3, r0rdy_3, r1rdy_3}); end
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) rst3_n = 1'b1;
            #1;
            n_tests++; if (rv_3 !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp%0d got %b want 0", i, rv_3); end
        end
        @(negedge clk);
        req1_valid = 1'b1; req1_opcode = 4'h2; req1_a = 8'h10; req1_b = 8'h20;
        #1;
        n_tests++; if ({r0rdy_3, r1rdy_3} !== 2'b01) begin n_fail++; $display("FAIL mid_req1_grant got %b want 01", {r0rdy_3, r1rdy_3}); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); req1_valid = 1'b0; #1;
            n_tests++; if ({rv_3, cs_3} !== {k == 4, k == 4}) begin n_fail++; $display("FAIL mid_lat%0d got valid,cs_n=%b want %b", k, {rv_3, cs_3}, {k == 4, k == 4}); end
        end
        n_tests++; if ({f_3, c_3, e_3, z_3, id_3} !== {8'h3B, 4'b0001}) begin n_fail++; $display("FAIL mid_rsp got %h want %h", {f_3, c_3, e_3, z_3, id_3}, {8'h3B, 4'b0001}); end
    endtask

    initial begin
        rst1_n = 1'b0; rst3_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_opcode = '0; req1_opcode = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mxalu_arb.md
MXALU_ARB -- requirements
Module: mxalu_arb

Interface
REQ-001 Parameter SETTLE, default 1, is the number of cycles (1..15) the ALU inputs are held with chip select active before results are captured.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_opcode / req1_opcode  input  4  ALU opcode.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  8 each  operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_f  output  8  captured ALU result.
REQ-011 rsp_carry  output  1  captured carry, equal to NOT alu_cn8_n.
REQ-012 rsp_eq  output  1  captured alu_a_b.
REQ-013 rsp_zero  output  1  set when the captured rsp_f is 8'h00.
REQ-014 rsp_id  output  1  index of the requester that owns the result.
REQ-015 alu_opcode  output  4; alu_a, alu_b  output  8 each; alu_cs_n  output  1  active-low ALU chip select.
REQ-016 alu_f  input  8; alu_cn8_n  input  1; alu_a_b  input  1  ALU outputs.
REQ-017 busy  output  1  state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-019 IDLE arbitration: exactly one ready SHALL be asserted combinationally, and only when its valid is high.
- Single valid: grant that requester.
- Both valid: grant the requester that is not last_id (round-robin).
REQ-020 On the handshake (valid & ready), the block SHALL:
- latch opcode, a, b and id into operand registers;
- load the settle counter with SETTLE-1;
- move to EXEC.
REQ-021 In EXEC and RESP, both readys SHALL be 0; no request is accepted.
REQ-022 In EXEC, the block SHALL drive alu_opcode/alu_a/alu_b from the operand registers with alu_cs_n=0.
- The counter decrements each cycle.
- In the cycle the counter is 0, the block SHALL capture rsp_f=alu_f, rsp_carry=~alu_cn8_n, rsp_eq=alu_a_b, rsp_zero=(alu_f==0), rsp_id=latched id.
- It then moves to RESP.
REQ-023 In IDLE and RESP, alu_cs_n SHALL be 1 and alu_opcode/alu_a/alu_b SHALL hold their last values.
REQ-024 rsp_valid SHALL be 1 exactly while in RESP.
- rsp_* SHALL stay stable until rsp_valid & rsp_ready.
- On that handshake: last_id<=rsp_id and the FSM returns to IDLE.
REQ-025 Latency: rsp_valid SHALL first be high SETTLE+1 cycles after the accepting edge.
- Minimum issue interval SHALL be SETTLE+2 cycles when rsp_ready is held high.
REQ-026 A requester dropping valid while not granted SHALL have no effect.
- Operand changes after the accepting edge SHALL NOT affect the result.
REQ-027 rsp_ready high while outside RESP SHALL be ignored.

Reset
REQ-028 Asserting rst_n low SHALL immediately force:
- state=IDLE, counter=0, last_id=1 (so req0 wins the first tie);
- rsp_valid=0, rsp_f=0, rsp_carry=0, rsp_eq=0, rsp_zero=0, rsp_id=0;
- alu_opcode=0, alu_a=0, alu_b=0, alu_cs_n=1, busy=0.
REQ-029 Reset during EXEC or RESP SHALL abandon the operation with no response; after release, the first request is treated as fresh.
REQ-030 Both readys SHALL be 0 while rst_n is low.

Verification
REQ-031 SETTLE=1; req0 op 4'h9, a=8'h3C, b=8'h0F; ALU model returns f=8'h4B, cn8_n=1, a_b=0.
- Required: req0_ready high in the accept cycle; alu_cs_n low for 1 cycle.
- Required: rsp_valid high 2 cycles after acceptance with rsp_f=8'h4B, carry=0, eq=0, zero=0, id=0.
REQ-032 Both valid continuously after reset, rsp_ready=1.
- Required: grants in the order 0,1,0,1, with responses spaced 3 cycles apart.
REQ-033 ALU model returns f=8'h00, cn8_n=0, a_b=1.
- Required: rsp_f=8'h00, carry=1, eq=1, zero=1.
REQ-034 rsp_ready held low for 5 cycles after rsp_valid.
- Required: rsp_* stable; req0/req1 ready stay 0; busy=1.
- Required: IDLE is reached one cycle after rsp_ready rises.
REQ-035 SETTLE=3; apply rst_n low during the second EXEC cycle.
- Required: alu_cs_n=1 and busy=0 immediately, and no rsp_valid ever appears.
- Required: after release, a req1-only request is granted with rsp_id=1 after 4 cycles.
